// File: rtl/trap_sequencer_pkg.sv
// rtl/trap_sequencer_pkg.sv - shared types and encodings for the user-mode trap sequencer
// Contents: FSM state encoding, utval source select, trap request struct,
// exception cause codes, ustatus UIE bit index and utvec mode encodings.
package trap_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAP_WR,
        ST_TRAP_JMP,
        ST_HANDLER,
        ST_RET_JMP
    } state_e;

    typedef enum logic [1:0] {
        UTVAL_ZERO,
        UTVAL_ADDR,
        UTVAL_WORD
    } utval_sel_e;

    localparam int CODE_W = 5;

    typedef struct packed {
        logic              valid;
        logic              is_interrupt;
        logic [CODE_W-1:0] code;
        utval_sel_e        utval_sel;
    } trap_req_t;

    localparam logic [CODE_W-1:0] EXC_INSTR_MISALIGNED = 5'd0;
    localparam logic [CODE_W-1:0] EXC_ILLEGAL          = 5'd2;
    localparam logic [CODE_W-1:0] EXC_EBREAK           = 5'd3;
    localparam logic [CODE_W-1:0] EXC_LOAD_MISALIGNED  = 5'd4;
    localparam logic [CODE_W-1:0] EXC_STORE_MISALIGNED = 5'd6;
    localparam logic [CODE_W-1:0] EXC_ECALL            = 5'd8;

    localparam int USTATUS_UIE_BIT = 0;

    localparam logic [1:0] MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_sequencer_priority_encoder.sv
// rtl/trap_sequencer_priority_encoder.sv - combinational trap priority encoder
// Inputs: already-qualified exception flags and masked interrupt requests
// irq = {ext, timer, sw}. Output: trap request {valid, is_interrupt, code, utval_sel}.
// Any exception outranks any interrupt.
module trap_priority_encoder
    import trap_sequencer_pkg::*;
#(
    parameter int CAUSE_USI = 0,
    parameter int CAUSE_UTI = 4,
    parameter int CAUSE_UEI = 8
) (
    input  logic       exc_instr_misaligned,
    input  logic       exc_illegal,
    input  logic       exc_ebreak,
    input  logic       exc_ecall,
    input  logic       exc_load_misaligned,
    input  logic       exc_store_misaligned,
    input  logic [2:0] irq,
    output trap_req_t  req
);

    always_comb begin
        req = '{valid: 1'b0, is_interrupt: 1'b0, code: '0, utval_sel: UTVAL_ZERO};
        if (exc_instr_misaligned) begin
            req = '{valid: 1'b1, is_interrupt: 1'b0, code: EXC_INSTR_MISALIGNED, utval_sel: UTVAL_ADDR};
        end else if (exc_illegal) begin
            req = '{valid: 1'b1, is_interrupt: 1'b0, code: EXC_ILLEGAL, utval_sel: UTVAL_WORD};
        end else if (exc_ebreak) begin
            req = '{valid: 1'b1, is_interrupt: 1'b0, code: EXC_EBREAK, utval_sel: UTVAL_ZERO};
        end else if (exc_ecall) begin
            req = '{valid: 1'b1, is_interrupt: 1'b0, code: EXC_ECALL, utval_sel: UTVAL_ZERO};
        end else if (exc_load_misaligned) begin
            req = '{valid: 1'b1, is_interrupt: 1'b0, code: EXC_LOAD_MISALIGNED, utval_sel: UTVAL_ADDR};
        end else if (exc_store_misaligned) begin
            req = '{valid: 1'b1, is_interrupt: 1'b0, code: EXC_STORE_MISALIGNED, utval_sel: UTVAL_ADDR};
        end else if (irq[2]) begin
            req = '{valid: 1'b1, is_interrupt: 1'b1, code: CODE_W'(CAUSE_UEI), utval_sel: UTVAL_ZERO};
        end else if (irq[0]) begin
            req = '{valid: 1'b1, is_interrupt: 1'b1, code: CODE_W'(CAUSE_USI), utval_sel: UTVAL_ZERO};
        end else if (irq[1]) begin
            req = '{valid: 1'b1, is_interrupt: 1'b1, code: CODE_W'(CAUSE_UTI), utval_sel: UTVAL_ZERO};
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - user-mode trap sequencer in front of the CSR file
// Detects exceptions/interrupts, writes uepc/ucause/utval as one strobe,
// redirects fetch into utvec and back to uepc on uret, tracks handler occupancy.
// Ports: core_clock/reset (async active-low); retire info (instr_*, mem_addr,
// exc_*, is_uret); irq_* with uie_mask {ext,timer,sw}; ustatus_in/utvec_in/uepc_in
// from the CSR file; csr_trap_write + trap_uepc/ucause/utval; flush;
// pc_redirect + pc_target; in_handler.
// Optional: TRAP_VECTORED_EN enables vectored interrupt targets (utvec mode 01).
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CAUSE_USI = 0,
    parameter int CAUSE_UTI = 4,
    parameter int CAUSE_UEI = 8
) (
    input  logic            core_clock,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instr_pc,
    input  logic [31:0]     instr_word,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            exc_instr_misaligned,
    input  logic            exc_illegal,
    input  logic            exc_ebreak,
    input  logic            exc_ecall,
    input  logic            exc_load_misaligned,
    input  logic            exc_store_misaligned,
    input  logic            is_uret,
    input  logic            irq_software,
    input  logic            irq_timer,
    input  logic            irq_external,
    input  logic [2:0]      uie_mask,
    input  logic [XLEN-1:0] ustatus_in,
    input  logic [XLEN-1:0] utvec_in,
    input  logic [XLEN-1:0] uepc_in,
    output logic            csr_trap_write,
    output logic [XLEN-1:0] trap_uepc,
    output logic [XLEN-1:0] trap_ucause,
    output logic [XLEN-1:0] trap_utval,
    output logic            flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            in_handler
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] uepc_q, uepc_d;
    logic [XLEN-1:0] ucause_q, ucause_d;
    logic [XLEN-1:0] utval_q, utval_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            in_handler_q, in_handler_d;

    logic            in_idle, trap_window, exc_en, irq_en;
    logic [2:0]      irq_masked;
    trap_req_t       req;
    logic [XLEN-1:0] new_uepc, new_ucause, new_utval;
    logic [XLEN-1:0] tvec_base, jump_target;
    logic            unused_inputs;

    assign in_idle     = (state_q == ST_IDLE);
    assign trap_window = in_idle || (state_q == ST_HANDLER);
    assign exc_en      = instr_valid && trap_window;
    // Interrupts are only taken outside the handler; that is the masking.
    assign irq_en      = instr_valid && in_idle && ustatus_in[USTATUS_UIE_BIT];
    assign irq_masked  = {irq_external, irq_timer, irq_software} & uie_mask & {3{irq_en}};

    // uret outside a handler has nothing to return to, so it is illegal.
    trap_priority_encoder #(
        .CAUSE_USI(CAUSE_USI),
        .CAUSE_UTI(CAUSE_UTI),
        .CAUSE_UEI(CAUSE_UEI)
    ) u_prio (
        .exc_instr_misaligned(exc_en && exc_instr_misaligned),
        .exc_illegal         (exc_en && (exc_illegal || (in_idle && is_uret))),
        .exc_ebreak          (exc_en && exc_ebreak),
        .exc_ecall           (exc_en && exc_ecall),
        .exc_load_misaligned (exc_en && exc_load_misaligned),
        .exc_store_misaligned(exc_en && exc_store_misaligned),
        .irq                 (irq_masked),
        .req                 (req)
    );

    always_comb begin
        // An interrupted instruction retires, so return lands after it.
        new_uepc = req.is_interrupt ? instr_pc + XLEN'(4) : instr_pc;
        new_ucause = '0;
        new_ucause[XLEN-1] = req.is_interrupt;
        new_ucause[CODE_W-1:0] = req.code;
        case (req.utval_sel)
            UTVAL_ADDR: new_utval = mem_addr;
            UTVAL_WORD: new_utval = XLEN'(instr_word);
            default:    new_utval = '0;
        endcase
    end

    assign tvec_base = {utvec_in[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign jump_target = (ucause_q[XLEN-1] && (utvec_in[1:0] == MODE_VECTORED))
                       ? tvec_base + (XLEN'(ucause_q[CODE_W-1:0]) << 2)
                       : tvec_base;
`else
    assign jump_target = tvec_base;
`endif
    assign unused_inputs = ^{ustatus_in[XLEN-1:1], utvec_in[1:0]};

    always_comb begin
        state_d        = state_q;
        uepc_d         = uepc_q;
        ucause_d       = ucause_q;
        utval_d        = utval_q;
        target_d       = target_q;
        in_handler_d   = in_handler_q;
        csr_trap_write = 1'b0;
        flush          = 1'b0;
        pc_redirect    = 1'b0;
        pc_target      = target_q;
        case (state_q)
            ST_IDLE, ST_HANDLER: begin
                if (req.valid) begin
                    state_d  = ST_TRAP_WR;
                    uepc_d   = new_uepc;
                    ucause_d = new_ucause;
                    utval_d  = new_utval;
                end else if ((state_q == ST_HANDLER) && instr_valid && is_uret) begin
                    state_d      = ST_RET_JMP;
                    in_handler_d = 1'b0;
                end
            end
            ST_TRAP_WR: begin
                csr_trap_write = 1'b1;
                flush          = 1'b1;
                state_d        = ST_TRAP_JMP;
            end
            ST_TRAP_JMP: begin
                // utvec is read here, a cycle after the CSR write strobe.
                pc_redirect  = 1'b1;
                pc_target    = jump_target;
                target_d     = jump_target;
                in_handler_d = 1'b1;
                state_d      = ST_HANDLER;
            end
            ST_RET_JMP: begin
                pc_redirect = 1'b1;
                flush       = 1'b1;
                pc_target   = uepc_in;
                target_d    = uepc_in;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            uepc_q       <= '0;
            ucause_q     <= '0;
            utval_q      <= '0;
            target_q     <= '0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            uepc_q       <= uepc_d;
            ucause_q     <= ucause_d;
            utval_q      <= utval_d;
            target_q     <= target_d;
            in_handler_q <= in_handler_d;
        end
    end

    assign trap_uepc   = uepc_q;
    assign trap_ucause = ucause_q;
    assign trap_utval  = utval_q;
    assign in_handler  = in_handler_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - self-checking bench for trap_sequencer
module tb_trap_sequencer;

    logic        core_clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_pc = '0, mem_addr = '0, instr_word = '0;
    logic        exc_instr_misaligned = 1'b0, exc_illegal = 1'b0, exc_ebreak = 1'b0;
    logic        exc_ecall = 1'b0, exc_load_misaligned = 1'b0, exc_store_misaligned = 1'b0;
    logic        is_uret = 1'b0;
    logic        irq_software = 1'b0, irq_timer = 1'b0, irq_external = 1'b0;
    logic [2:0]  uie_mask = '0;
    logic [31:0] ustatus_in = '0, utvec_in = '0, uepc_in = '0;
    logic        csr_trap_write, flush, pc_redirect, in_handler;
    logic [31:0] trap_uepc, trap_ucause, trap_utval, pc_target;

    int total = 0;
    int bad = 0;

    trap_sequencer #(.XLEN(32)) dut (
        .core_clock(core_clock), .reset(reset), .instr_valid(instr_valid),
        .instr_pc(instr_pc), .instr_word(instr_word), .mem_addr(mem_addr),
        .exc_instr_misaligned(exc_instr_misaligned), .exc_illegal(exc_illegal),
        .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
        .exc_load_misaligned(exc_load_misaligned), .exc_store_misaligned(exc_store_misaligned),
        .is_uret(is_uret), .irq_software(irq_software), .irq_timer(irq_timer),
        .irq_external(irq_external), .uie_mask(uie_mask), .ustatus_in(ustatus_in),
        .utvec_in(utvec_in), .uepc_in(uepc_in), .csr_trap_write(csr_trap_write),
        .trap_uepc(trap_uepc), .trap_ucause(trap_ucause), .trap_utval(trap_utval),
        .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .in_handler(in_handler)
    );

    always #5 core_clock = ~core_clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_write_due, m_jump_due, m_ret_due, m_in_handler;
    logic [31:0] m_uepc, m_cause, m_tval, m_target;

    function automatic void pick(output bit hit, output bit irq, output int code);
        int codes[6];
        bit [5:0] f;
        bit [2:0] pend;
        codes = '{0, 2, 3, 8, 4, 6};
        f = {exc_store_misaligned, exc_load_misaligned, exc_ecall, exc_ebreak,
             exc_illegal | (!m_in_handler && is_uret), exc_instr_misaligned};
        hit = 0; irq = 0; code = 0;
        for (int i = 0; i < 6; i++)
            if (!hit && f[i]) begin hit = 1; code = codes[i]; end
        pend = {irq_external, irq_timer, irq_software} & uie_mask;
        if (!hit && !m_in_handler && ustatus_in[0] && pend != 0) begin
            hit = 1; irq = 1;
            code = pend[2] ? 8 : pend[0] ? 0 : 4;
        end
    endfunction

    function automatic logic [31:0] exp_jump();
        logic [31:0] b;
        b = {utvec_in[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (m_cause[31] && utvec_in[1:0] == 2'b01) b = b + 4 * m_cause[7:0];
`endif
        return b;
    endfunction

    always @(posedge core_clock or negedge reset) begin
        if (!reset) begin
            m_write_due <= 0; m_jump_due <= 0; m_ret_due <= 0; m_in_handler <= 0;
            m_uepc <= '0; m_cause <= '0; m_tval <= '0; m_target <= '0;
        end else if (m_write_due) begin
            m_write_due <= 0; m_jump_due <= 1;
        end else if (m_jump_due) begin
            m_jump_due <= 0; m_in_handler <= 1; m_target <= exp_jump();
        end else if (m_ret_due) begin
            m_ret_due <= 0; m_target <= uepc_in;
        end else if (instr_valid) begin : decide
            bit h, ii;
            int c;
            pick(h, ii, c);
            if (h) begin
                m_write_due <= 1;
                m_uepc  <= ii ? instr_pc + 32'd4 : instr_pc;
                m_cause <= (ii ? 32'h8000_0000 : 32'h0) | 32'(c);
                m_tval  <= (!ii && (c == 0 || c == 4 || c == 6)) ? mem_addr :
                           (!ii && c == 2) ? instr_word : 32'h0;
            end else if (m_in_handler && is_uret) begin
                m_ret_due <= 1; m_in_handler <= 0;
            end
        end
    end

    always @(negedge core_clock) begin
        chk("m.write",    32'(csr_trap_write), 32'(m_write_due));
        chk("m.flush",    32'(flush),          32'(m_write_due | m_ret_due));
        chk("m.redirect", 32'(pc_redirect),    32'(m_jump_due | m_ret_due));
        chk("m.target",   pc_target, m_jump_due ? exp_jump() : m_ret_due ? uepc_in : m_target);
        chk("m.uepc",     trap_uepc,   m_uepc);
        chk("m.ucause",   trap_ucause, m_cause);
        chk("m.utval",    trap_utval,  m_tval);
        chk("m.handler",  32'(in_handler), 32'(m_in_handler));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge core_clock); #1;
    endtask

    task automatic clr();
        instr_valid = 0; is_uret = 0;
        exc_instr_misaligned = 0; exc_illegal = 0; exc_ebreak = 0;
        exc_ecall = 0; exc_load_misaligned = 0; exc_store_misaligned = 0;
    endtask

    // Inputs for the trap are set by the caller; ends inside HANDLER.
    task automatic trap_case(input string nm, input logic [31:0] e_uepc, input logic [31:0] e_cause,
                             input logic [31:0] e_tval, input logic [31:0] e_tgt, input logic e_ih);
        tick(); clr(); #1;
        chk({nm, ".write"}, 32'(csr_trap_write), 32'd1);
        chk({nm, ".uepc"}, trap_uepc, e_uepc);
        chk({nm, ".ucause"}, trap_ucause, e_cause);
        chk({nm, ".utval"}, trap_utval, e_tval);
        chk({nm, ".ih_wr"}, 32'(in_handler), 32'(e_ih));
        tick(); #1;
        chk({nm, ".redirect"}, 32'(pc_redirect), 32'd1);
        chk({nm, ".target"}, pc_target, e_tgt);
        tick(); #1;
        chk({nm, ".in_handler"}, 32'(in_handler), 32'd1);
    endtask

    task automatic exit_handler(input string nm, input logic [31:0] ret);
        uepc_in = ret; instr_valid = 1; is_uret = 1;
        tick(); clr(); #1;
        chk({nm, ".ret_redirect"}, 32'(pc_redirect), 32'd1);
        chk({nm, ".ret_target"}, pc_target, ret);
        tick();
    endtask

    initial begin
        repeat (2) @(posedge core_clock);
        #1;
        chk("rst.write", 32'(csr_trap_write), 32'd0);
        chk("rst.target", pc_target, 32'd0);
        reset = 1;
        tick();

        utvec_in = 32'h0040_0100;
        instr_valid = 1; instr_pc = 32'h0040_0010; instr_word = 32'hFFFF_FFFF; exc_illegal = 1;
        trap_case("illegal", 32'h0040_0010, 32'h2, 32'hFFFF_FFFF, 32'h0040_0100, 0);
        exit_handler("illegal", 32'h0040_0014);

        instr_valid = 1; instr_pc = 32'h0040_0030; mem_addr = 32'h1003;
        exc_ecall = 1; exc_load_misaligned = 1;
        trap_case("ecall_ld", 32'h0040_0030, 32'h8, 32'h0, 32'h0040_0100, 0);
        exit_handler("ecall_ld", 32'h0040_0034);

        utvec_in = 32'h0040_0101; ustatus_in = 1; uie_mask = 3'b010; irq_timer = 1;
        instr_valid = 1; instr_pc = 32'h0040_0020;
`ifdef TRAP_VECTORED_EN
        trap_case("timer", 32'h0040_0024, 32'h8000_0004, 32'h0, 32'h0040_0110, 0);
`else
        trap_case("timer", 32'h0040_0024, 32'h8000_0004, 32'h0, 32'h0040_0100, 0);
`endif
        instr_valid = 1; instr_pc = 32'h0040_0100;
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            chk("masked_irq.write", 32'(csr_trap_write), 32'd0);
        end
        uepc_in = 32'h0040_0024; is_uret = 1;
        tick(); is_uret = 0; instr_pc = 32'h0040_0024; #1;
        chk("uret.redirect", 32'(pc_redirect), 32'd1);
        chk("uret.target", pc_target, 32'h0040_0024);
        chk("uret.flush", 32'(flush), 32'd1);
        tick(); #1;
        chk("uret.idle_ih", 32'(in_handler), 32'd0);
`ifdef TRAP_VECTORED_EN
        trap_case("irq_after_ret", 32'h0040_0028, 32'h8000_0004, 32'h0, 32'h0040_0110, 0);
`else
        trap_case("irq_after_ret", 32'h0040_0028, 32'h8000_0004, 32'h0, 32'h0040_0100, 0);
`endif
        irq_timer = 0;

        instr_valid = 1; instr_pc = 32'h0040_0040; mem_addr = 32'h2002; exc_load_misaligned = 1;
`ifdef TRAP_VECTORED_EN
        trap_case("nested", 32'h0040_0040, 32'h4, 32'h2002, 32'h0040_0100, 1);
`else
        trap_case("nested", 32'h0040_0040, 32'h4, 32'h2002, 32'h0040_0100, 1);
`endif
        exit_handler("nested", 32'h0040_0028);

        // vectored utvec but an exception: always base
        instr_valid = 1; instr_pc = 32'h0040_0050; exc_ecall = 1;
        trap_case("exc_vec_mode", 32'h0040_0050, 32'h8, 32'h0, 32'h0040_0100, 0);
        exit_handler("exc_vec_mode", 32'h0040_0054);
        utvec_in = 32'h0040_0100;

        instr_valid = 1; instr_pc = 32'h0000_1000; mem_addr = 32'h5001; instr_word = 32'h1234_5678;
        exc_instr_misaligned = 1; exc_illegal = 1; exc_ebreak = 1; exc_ecall = 1;
        exc_load_misaligned = 1; exc_store_misaligned = 1; irq_external = 1; uie_mask = 3'b111;
        trap_case("all_exc", 32'h0000_1000, 32'h0, 32'h5001, 32'h0040_0100, 0);
        irq_external = 0;
        exit_handler("all_exc", 32'h0000_1004);

        instr_valid = 1; instr_pc = 32'h0000_2000; mem_addr = 32'h7006; exc_store_misaligned = 1;
        trap_case("store_mis", 32'h0000_2000, 32'h6, 32'h7006, 32'h0040_0100, 0);
        exit_handler("store_mis", 32'h0000_2004);

        instr_valid = 1; instr_pc = 32'h0000_3000; exc_ebreak = 1;
        trap_case("ebreak", 32'h0000_3000, 32'h3, 32'h0, 32'h0040_0100, 0);
        exit_handler("ebreak", 32'h0000_3004);

        instr_valid = 1; instr_pc = 32'h0000_4000; instr_word = 32'h0020_0073; is_uret = 1;
        trap_case("uret_idle", 32'h0000_4000, 32'h2, 32'h0020_0073, 32'h0040_0100, 0);
        exit_handler("uret_idle", 32'h0000_4004);

        irq_software = 1; irq_timer = 1; irq_external = 1; uie_mask = 3'b111;
        instr_valid = 1; instr_pc = 32'h0000_5000;
        trap_case("ext_first", 32'h0000_5004, 32'h8000_0008, 32'h0, 32'h0040_0100, 0);
        uie_mask = 3'b011;
        exit_handler("ext_first", 32'h0000_5004);
        instr_valid = 1;
        trap_case("sw_over_timer", 32'h0000_5004, 32'h8000_0000, 32'h0, 32'h0040_0100, 0);
        irq_software = 0; irq_timer = 0; irq_external = 0;
        exit_handler("sw_over_timer", 32'h0000_5004);

        ustatus_in = 0; irq_external = 1; uie_mask = 3'b111; instr_valid = 1;
        tick(); #1;
        chk("uie_off.write", 32'(csr_trap_write), 32'd0);
        tick(); #1;
        chk("uie_off.write2", 32'(csr_trap_write), 32'd0);
        ustatus_in = 1; instr_pc = 32'hFFFF_FFFC;
        trap_case("wrap", 32'h0, 32'h8000_0008, 32'h0, 32'h0040_0100, 0);
        irq_external = 0;
        exit_handler("wrap", 32'h0);

        instr_valid = 1; instr_pc = 32'h0000_6000; exc_illegal = 1; instr_word = 32'hDEAD_BEEF;
        tick(); clr(); #1;
        chk("rst_mid.write_before", 32'(csr_trap_write), 32'd1);
        reset = 0; #1;
        chk("rst_mid.write", 32'(csr_trap_write), 32'd0);
        chk("rst_mid.flush", 32'(flush), 32'd0);
        chk("rst_mid.uepc", trap_uepc, 32'd0);
        chk("rst_mid.ucause", trap_ucause, 32'd0);
        tick(); tick();
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("rst_mid.no_redirect", 32'(pc_redirect), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
